// File: rtl/mips_pkg.sv
// mips_pkg: control encodings shared by the multi-cycle controller and datapath
package mips_pkg;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two async reads, one sync write, r0 hardwired to zero
module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  always_comb begin
    rf_d = rf_q;
    if (we && wa != 5'd0) rf_d[wa] = wd;
  end
  always_ff @(posedge clk) begin
    if (reset) rf_q <= '{default: '0};
    else rf_q <= rf_d;
  end
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf_q[ra2];
endmodule

// File: rtl/mips_mc_datapath.sv
// mips_mc_datapath: multi-cycle MIPS datapath driven by per-cycle controller strobes
module mips_mc_datapath
  import mips_pkg::*;
#(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcen,
  input  logic             irwrite,
  input  logic             regwrite,
  input  logic             alusrca,
  input  logic             iord,
  input  logic             memtoreg,
  input  logic             regdst,
  input  logic [1:0]       alusrcb,
  input  logic [1:0]       pcsrc,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] readdata,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic             zero,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata
);
  logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d, a_q, a_d, b_q, b_d, aluout_q, aluout_d;
  logic [WIDTH-1:0] src_a, src_b, sign_imm, alu_result, pc_next, rd1, rd2, wd3;
  logic [4:0]       wa3;
  mips_regfile u_rf (
    .clk(clk), .reset(reset), .we(regwrite),
    .ra1(ir_q[25:21]), .ra2(ir_q[20:16]), .wa(wa3), .wd(wd3),
    .rd1(rd1), .rd2(rd2)
  );
  always_comb begin
    sign_imm = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
    src_a = alusrca ? a_q : pc_q;
    src_b = alusrcb == SRCB_B    ? b_q :
            alusrcb == SRCB_FOUR ? WIDTH'(4) :
            alusrcb == SRCB_IMM  ? sign_imm : {sign_imm[WIDTH-3:0], 2'b00};
    case (alucontrol)
      ALUCTL_ADD: alu_result = src_a + src_b;
      ALUCTL_SUB: alu_result = src_a - src_b;
      ALUCTL_AND: alu_result = src_a & src_b;
      ALUCTL_OR:  alu_result = src_a | src_b;
      ALUCTL_SLT: alu_result = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      default:    alu_result = '0;
    endcase
    // reserved pcsrc encoding reloads the current PC, i.e. holds
    pc_next = pcsrc == PCSRC_ALU    ? alu_result :
              pcsrc == PCSRC_ALUOUT ? aluout_q :
              pcsrc == PCSRC_JUMP   ? {pc_q[WIDTH-1:WIDTH-4], ir_q[25:0], 2'b00} : pc_q;
    wa3 = regdst ? ir_q[15:11] : ir_q[20:16];
    wd3 = memtoreg ? mdr_q : aluout_q;
    pc_d = pcen ? pc_next : pc_q;
    ir_d = irwrite ? readdata : ir_q;
    mdr_d = readdata;
    a_d = rd1;
    b_d = rd2;
    aluout_d = alu_result;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
      mdr_q <= '0;
      a_q <= '0;
      b_q <= '0;
      aluout_q <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      mdr_q <= mdr_d;
      a_q <= a_d;
      b_q <= b_d;
      aluout_q <= aluout_d;
    end
  end
  assign op = ir_q[31:26];
  assign funct = ir_q[5:0];
  assign zero = alu_result == '0;
  assign adr = iord ? aluout_q : pc_q;
  assign writedata = b_q;
endmodule
